// File: rtl/exec_stage.sv
// exec_stage: ALU execute stage feeding a 2-entry in-order result buffer.
// Optional operand forwarding from the last accepted bundle is enabled by defining EXEC_FORWARD_EN.
module exec_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] immextend,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic              rwrite,
  input  logic              we,
  input  logic              selectmem,
  input  logic [2:0]        alusignal,
  input  logic              opbselect,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_data,
  output logic [3:0]        out_rd,
  output logic              out_rwrite,
  output logic              out_we,
  output logic              out_selectmem,
  output logic              flag_z,
  output logic              flag_n
);

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sdata;
    logic [3:0]        rd;
    logic              rwrite;
    logic              we;
    logic              selmem;
  } entry_t;

  logic [1:0]        cnt_p1;
  entry_t            head_p1;
  entry_t            tail_p1;
  entry_t            new_p0;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_reg_p0;
  logic [DATA_W-1:0] b_p0;

  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << b[4:0];
      3'b110:  r = a >> b[4:0];
      default: r = b;
    endcase
    return r;
  endfunction

  // in_ready depends only on occupancy, so a full buffer never accepts even while popping.
  assign in_ready  = ~reset & (cnt_p1 != 2'd2);
  assign out_valid = (cnt_p1 != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef EXEC_FORWARD_EN
  logic              fwd_vld_p1;
  logic [3:0]        fwd_rd_p1;
  logic              fwd_rwrite_p1;
  logic [DATA_W-1:0] fwd_res_p1;
  logic              hit1_p0;
  logic              hit2_p0;

  assign hit1_p0  = fwd_vld_p1 & fwd_rwrite_p1 & (rs1 == fwd_rd_p1);
  assign hit2_p0  = fwd_vld_p1 & fwd_rwrite_p1 & (rs2 == fwd_rd_p1);
  assign a_p0     = hit1_p0 ? fwd_res_p1 : data1;
  assign b_reg_p0 = hit2_p0 ? fwd_res_p1 : data2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      fwd_vld_p1 <= 1'b0;
    else if (flush) fwd_vld_p1 <= 1'b0;
    else if (push)  fwd_vld_p1 <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      fwd_rd_p1     <= rd;
      fwd_rwrite_p1 <= rwrite;
      fwd_res_p1    <= new_p0.res;
    end
  end
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign a_p0      = data1;
  assign b_reg_p0  = data2;
`endif

  assign b_p0   = opbselect ? immextend : b_reg_p0;
  assign new_p0 = '{res: alu_f(alusignal, a_p0, b_p0), sdata: b_reg_p0, rd: rd,
                    rwrite: rwrite, we: we, selmem: selectmem};

  // Stage p1: two-entry buffer, head entry drives every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p1  <= 2'd0;
      head_p1 <= '0;
    end else if (flush) begin
      cnt_p1 <= 2'd0;
    end else begin
      cnt_p1 <= cnt_p1 + 2'(push) - 2'(pop);
      if (pop && cnt_p1 == 2'd2)
        head_p1 <= tail_p1;
      else if (push && (cnt_p1 == 2'd0 || pop))
        head_p1 <= new_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && push && !pop && cnt_p1 == 2'd1)
      tail_p1 <= new_p0;
  end

  assign alu_result    = head_p1.res;
  assign store_data    = head_p1.sdata;
  assign out_rd        = head_p1.rd;
  assign out_rwrite    = head_p1.rwrite;
  assign out_we        = head_p1.we;
  assign out_selectmem = head_p1.selmem;
  assign flag_z        = (head_p1.res == '0);
  assign flag_n        = head_p1.res[DATA_W-1];

endmodule
